// File: rtl/bpsk_demod.sv
// bpsk_demod: BPSK integrate-and-dump demodulator.
// Three-stage pipe: sample conversion/register, signed multiply, accumulate.
// The chip FSM runs on the product stage, so a chip's bit is decided in the
// same edge that adds its last product.
// Optional macro DEMOD_DIFF_EN: differential decoding of the emitted bit.
module bpsk_demod #(
  parameter int              CHIP_LEN = 64,
  parameter int              CNT_W    = 7,
  parameter int              ACC_W    = 34,
  parameter longint unsigned THRESH   = 64'd1048576,
  parameter logic [13:0]     ADC_ZERO = 14'h2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sample_valid,
  input  logic [13:0]      adc_data,
  input  logic [13:0]      ref_data,
  input  logic             chip_sync,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [ACC_W-1:0] corr_out,
  output logic             low_conf,
  output logic             sync_err
);

  typedef enum logic [1:0] {IDLE, INTEG, DUMP} state_t;

  // stage 1: converted sample, carrier replica and qualifiers
  logic               s1_valid_q, s1_valid_d;
  logic               s1_sync_q, s1_sync_d;
  logic signed [13:0] s1_s_q, s1_s_d;
  logic signed [13:0] s1_ref_q, s1_ref_d;
  // stage 2: product
  logic               s2_valid_q, s2_valid_d;
  logic               s2_sync_q, s2_sync_d;
  logic signed [27:0] s2_prod_q, s2_prod_d;
  // stage 3: integrator and chip FSM
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic [ACC_W-1:0]   corr_q, corr_d;
  logic               low_conf_q, low_conf_d;
  logic               sync_err_q, sync_err_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   sum_abs;
  logic [CNT_W-1:0]   cnt_inc;
  logic               raw;

`ifdef DEMOD_DIFF_EN
  logic               prev_raw_q, prev_raw_d;
`endif

  // Input stages: valid flags shift every cycle; data only updates on valid.
  // XOR with midscale flips the MSB, turning offset binary into two's complement.
  always_comb begin
    s1_valid_d = sample_valid & en;
    s1_sync_d  = chip_sync;
    s1_s_d     = s1_s_q;
    s1_ref_d   = s1_ref_q;
    if (sample_valid) begin
      s1_s_d   = adc_data ^ ADC_ZERO;
      s1_ref_d = ref_data;
    end
    s2_valid_d = s1_valid_q & en;
    s2_sync_d  = s1_sync_q;
    s2_prod_d  = s2_prod_q;
    if (s1_valid_q) begin
      s2_prod_d = 28'(s1_s_q) * 28'(s1_ref_q);
    end
  end

  // Chip FSM: accumulate, dump on the CHIP_LEN-th product, resync on mid-chip sync.
  always_comb begin
    prod_ext    = {{(ACC_W-28){s2_prod_q[27]}}, s2_prod_q};
    sum         = acc_q + prod_ext;
    sum_abs     = sum[ACC_W-1] ? (~sum + 1'b1) : sum;
    cnt_inc     = cnt_q + 1'b1;
    raw         = ~sum[ACC_W-1];
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    corr_d      = corr_q;
    low_conf_d  = low_conf_q;
    sync_err_d  = 1'b0;
`ifdef DEMOD_DIFF_EN
    prev_raw_d  = prev_raw_q;
`endif
    case (state_q)
      IDLE: begin
        if (s2_valid_q && s2_sync_q) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = INTEG;
        end
      end
      INTEG: begin
        if (s2_valid_q) begin
          if (s2_sync_q && cnt_q != '0) begin
            // restart with this sample as sample 1 of a new chip
            sync_err_d = 1'b1;
            acc_d      = prod_ext;
            cnt_d      = CNT_W'(1);
          end else if (cnt_inc == CNT_W'(CHIP_LEN)) begin
            bit_valid_d = 1'b1;
            corr_d      = sum;
            low_conf_d  = (sum_abs < ACC_W'(THRESH));
`ifdef DEMOD_DIFF_EN
            bit_out_d   = ~(raw ^ prev_raw_q);
            prev_raw_d  = raw;
`else
            bit_out_d   = raw;
`endif
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = DUMP;
          end else begin
            acc_d = sum;
            cnt_d = cnt_inc;
          end
        end
      end
      DUMP: begin
        // a back-to-back chip's first product seeds the fresh accumulator
        if (s2_valid_q && s2_sync_q) begin
          acc_d   = prod_ext;
          cnt_d   = CNT_W'(1);
          state_d = INTEG;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DEMOD_DIFF_EN
    if (state_q == IDLE || sync_err_d) begin
      prev_raw_d = 1'b1;
    end
`endif
    if (!en) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      bit_valid_d = 1'b0;
      sync_err_d  = 1'b0;
    end
  end

  // State and pipe registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sync_q   <= 1'b0;
      s1_s_q      <= '0;
      s1_ref_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sync_q   <= 1'b0;
      s2_prod_q   <= '0;
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      corr_q      <= '0;
      low_conf_q  <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sync_q   <= s1_sync_d;
      s1_s_q      <= s1_s_d;
      s1_ref_q    <= s1_ref_d;
      s2_valid_q  <= s2_valid_d;
      s2_sync_q   <= s2_sync_d;
      s2_prod_q   <= s2_prod_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      corr_q      <= corr_d;
      low_conf_q  <= low_conf_d;
      sync_err_q  <= sync_err_d;
    end
  end

`ifdef DEMOD_DIFF_EN
  // Previous raw decision for differential decoding.
  always_ff @(posedge clk) begin
    if (rst) prev_raw_q <= 1'b1;
    else     prev_raw_q <= prev_raw_d;
  end
`endif

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign corr_out  = corr_q;
  assign low_conf  = low_conf_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_bpsk_demod.sv
// Testbench for bpsk_demod: directed chips, expected bits pushed to a
// scoreboard queue at stimulus time and compared when the strobes appear.
module tb_bpsk_demod;
  localparam int CHIP_LEN = 64;
  localparam int ACC_W    = 34;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sample_valid;
  logic [13:0]      adc_data;
  logic [13:0]      ref_data;
  logic             chip_sync;
  logic             bit_out;
  logic             bit_valid;
  logic [ACC_W-1:0] corr_out;
  logic             low_conf;
  logic             sync_err;

  bpsk_demod dut (
    .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid),
    .adc_data(adc_data), .ref_data(ref_data), .chip_sync(chip_sync),
    .bit_out(bit_out), .bit_valid(bit_valid), .corr_out(corr_out),
    .low_conf(low_conf), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint corr;
    logic   b;
    logic   lc;
    int     at_edge;
  } exp_t;

  exp_t   bit_q[$];
  int     serr_q[$];
  int     checks   = 0;
  int     errors   = 0;
  int     edge_cnt = 0;

  // reference model state
  longint m_acc    = 0;
  int     m_cnt    = 0;
  bit     m_in     = 0;
  bit     m_prev   = 1;
  int     m_last   = -10;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(got), $signed(want));
    end
  endtask

  // model of one valid sample sampled at posedge number n
  task automatic model_step(input int a, input int r, input bit sync, input int n);
    bit     raw;
    bit     b;
    longint mag;
    exp_t   e;
    if (sync) begin
      if (m_in && m_cnt != 0) begin
        serr_q.push_back(n + 2);
        m_prev = 1;
      end else if (n != m_last + 1) begin
        m_prev = 1;
      end
      m_in  = 1;
      m_cnt = 0;
      m_acc = 0;
    end
    if (m_in) begin
      m_acc += longint'(a) * longint'(r);
      m_cnt++;
      if (m_cnt == CHIP_LEN) begin
        raw = (m_acc >= 0);
`ifdef DEMOD_DIFF_EN
        b = ~(raw ^ m_prev);
`else
        b = raw;
`endif
        m_prev    = raw;
        mag       = (m_acc < 0) ? -m_acc : m_acc;
        e.corr    = m_acc;
        e.b       = b;
        e.lc      = (mag < 64'd1048576);
        e.at_edge = n + 2;
        bit_q.push_back(e);
        m_in   = 0;
        m_cnt  = 0;
        m_last = n;
      end
    end
  endtask

  task automatic send(input int a, input int r, input bit sync);
    @(negedge clk);
    sample_valid = 1'b1;
    chip_sync    = sync;
    adc_data     = 14'(a + 8192);
    ref_data     = 14'(r);
    model_step(a, r, sync, edge_cnt + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      chip_sync    = 1'b0;
    end
  endtask

  task automatic chip(input int a, input int r);
    for (int i = 0; i < CHIP_LEN; i++) send(a, r, i == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; chip_sync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_in = 0; m_cnt = 0; m_prev = 1;
    chk("rst_bit_valid", 64'(bit_valid), 64'd0);
    chk("rst_bit_out",   64'(bit_out),   64'd0);
    chk("rst_corr_out",  64'(corr_out),  64'd0);
    chk("rst_low_conf",  64'(low_conf),  64'd0);
    chk("rst_sync_err",  64'(sync_err),  64'd0);
  endtask

  initial begin
    int   code4[4];
    int   code6[5];
    exp_t e;
    rst = 1'b1; en = 1'b1; sample_valid = 1'b0; chip_sync = 1'b0;
    adc_data = 14'h2000; ref_data = '0;

    // monitor: every posedge, compare strobes against the scoreboard
    fork
      forever begin
        @(posedge clk);
        #1;
        edge_cnt++;
        if (bit_q.size() > 0 && bit_q[0].at_edge == edge_cnt) begin
          e = bit_q.pop_front();
          chk("bit_valid", 64'(bit_valid), 64'd1);
          chk("bit_out",   64'(bit_out),   64'(e.b));
          chk("corr_out",  64'($signed(corr_out)), 64'(e.corr));
          chk("low_conf",  64'(low_conf),  64'(e.lc));
          $display("bit edge=%0d bit=%0b corr=%0d low_conf=%0b", edge_cnt, bit_out, $signed(corr_out), low_conf);
        end else begin
          chk("no_bit_valid", 64'(bit_valid), 64'd0);
        end
        if (serr_q.size() > 0 && serr_q[0] == edge_cnt) begin
          void'(serr_q.pop_front());
          chk("sync_err", 64'(sync_err), 64'd1);
          $display("sync_err edge=%0d", edge_cnt);
        end else begin
          chk("no_sync_err", 64'(sync_err), 64'd0);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    do_reset();

    // 1/2: strong in-phase and inverted chips
    chip(1000, 1000);
    idle(4);
    chip(-1000, 1000);
    idle(4);
    // 3: weak chip, then code 1,0,1,1 back-to-back
    chip(10, 10);
    code4 = '{1, 0, 1, 1};
    idle(4);
    for (int k = 0; k < 4; k++) chip(code4[k] ? 500 : -500, 700);
    idle(4);
    // 4: resync at sample 30, then a full chip from the resync
    for (int i = 0; i < 30 + CHIP_LEN; i++) send((i * 37 % 200) - 100, 900, i == 0 || i == 30);
    idle(4);
    // 5: 50% sample_valid within a chip
    for (int i = 0; i < CHIP_LEN; i++) begin
      send(1000, 1000, i == 0);
      idle(1);
    end
    idle(4);
    // 5: reset at sample 40 discards the chip
    for (int i = 0; i < 40; i++) send(800, 800, i == 0);
    do_reset();
    chip(-300, 200);
    idle(4);
    // en dropped mid-chip discards the partial chip
    for (int i = 0; i < 20; i++) send(600, 600, i == 0);
    @(negedge clk);
    en = 1'b0; sample_valid = 1'b0; chip_sync = 1'b0;
    m_in = 0; m_cnt = 0; m_prev = 1;
    @(negedge clk);
    en = 1'b1;
    idle(3);
    chip(600, 600);
    idle(4);
    // 6: raw chips 1,1,0,0,1 back-to-back, negative carrier
    code6 = '{1, 1, 0, 0, 1};
    for (int k = 0; k < 5; k++) chip(code6[k] ? -400 : 400, -300);
    idle(4);
    // full-scale random samples, two back-to-back chips
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < CHIP_LEN; i++)
        send(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192, i == 0);
    idle(8);

    chk("bit_queue_drained", 64'(bit_q.size()), 64'd0);
    chk("serr_queue_drained", 64'(serr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
